// File: rtl/fetch_unit.sv
// Instruction fetch unit: three-state IDLE/FETCH/HOLD sequencer that reads one
// instruction per request into ir and advances the PC, with redirect via pc_ld.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        pc_ld,
  input  logic [15:0] pc_in,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ack,
  output logic [15:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;

  // Handshake outputs depend only on the registered state.
  assign mem_rd   = (state == FETCH);
  assign ir_valid = (state == HOLD);
  assign mem_addr = pc;
  assign pc_out   = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (pc_ld) pc <= pc_in;
          if (run) state <= FETCH;
        end
        FETCH: begin
          // A redirect wins over a same-cycle response; the stale word is dropped.
          if (pc_ld) begin
            pc <= pc_in;
          end else if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 16'd1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (pc_ld) pc <= pc_in;
          if (ir_ack) state <= run ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected (ir, pc_out) pairs are queued at
// stimulus time and retired by a monitor on each consumed instruction.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        run;
  logic        pc_ld;
  logic [15:0] pc_in;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ack;
  logic [15:0] pc_out;

  int tests = 0;
  int fails = 0;
  logic [31:0] expq[$];

  fetch_unit #(.RESET_PC(16'h3000)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_ld(pc_ld), .pc_in(pc_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .ir(ir), .ir_valid(ir_valid), .ir_ack(ir_ack),
    .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire one expected instruction per consumed ir.
  always @(negedge clk) begin
    if (!rst && ir_valid && ir_ack) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_empty: got ir %h with no expected entry", ir);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        chk("mon_ir", ir, e[31:16]);
        chk("mon_pc", pc_out, e[15:0]);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; pc_ld = 1'b0; pc_in = 16'h0000;
    mem_rdata = 16'h0000; mem_ready = 1'b0; ir_ack = 1'b0;
    cyc(); cyc();
    chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_pc_out", pc_out, 16'h3000);
    chk("rst_mem_addr", mem_addr, 16'h3000);
    chk("rst_ir", ir, 16'h0000);

    // Minimum latency fetch
    rst = 1'b0; run = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1261;
    expq.push_back({16'h1261, 16'h3001});
    cyc();
    chk("lat_mem_rd", {15'd0, mem_rd}, 16'd1);
    chk("lat_ir_valid0", {15'd0, ir_valid}, 16'd0);
    cyc();
    chk("lat_ir_valid", {15'd0, ir_valid}, 16'd1);
    chk("lat_ir", ir, 16'h1261);
    chk("lat_pc_out", pc_out, 16'h3001);
    chk("lat_no_rd", {15'd0, mem_rd}, 16'd0);
    run = 1'b0; ir_ack = 1'b1;
    cyc();
    chk("lat_idle_rd", {15'd0, mem_rd}, 16'd0);
    chk("lat_idle_valid", {15'd0, ir_valid}, 16'd0);
    ir_ack = 1'b0;

    // Wait states; run dropped mid-fetch must not abort it
    rst = 1'b1;
    cyc();
    rst = 1'b0; run = 1'b1; mem_ready = 1'b0; mem_rdata = 16'hABCD;
    cyc();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ws_mem_addr", mem_addr, 16'h3000);
      chk("ws_mem_rd", {15'd0, mem_rd}, 16'd1);
      chk("ws_ir_valid", {15'd0, ir_valid}, 16'd0);
    end
    mem_ready = 1'b1;
    expq.push_back({16'hABCD, 16'h3001});
    cyc();
    chk("ws_ir_valid_cap", {15'd0, ir_valid}, 16'd1);
    chk("ws_ir", ir, 16'hABCD);
    ir_ack = 1'b1;
    cyc();
    chk("ws_idle_rd", {15'd0, mem_rd}, 16'd0);
    ir_ack = 1'b0;

    // Redirect during fetch discards same-cycle data
    run = 1'b1; mem_ready = 1'b0;
    cyc();
    pc_ld = 1'b1; pc_in = 16'h4000; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    cyc();
    chk("redir_mem_addr", mem_addr, 16'h4000);
    chk("redir_mem_rd", {15'd0, mem_rd}, 16'd1);
    chk("redir_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("redir_ir_kept", ir, 16'hABCD);
    pc_ld = 1'b0; mem_ready = 1'b0;
    cyc();
    chk("redir_hold_addr", mem_addr, 16'h4000);
    mem_ready = 1'b1; mem_rdata = 16'h5555; run = 1'b0;
    expq.push_back({16'h5555, 16'h4001});
    cyc();
    chk("redir_cap_ir", ir, 16'h5555);

    // HOLD without ack keeps ir and issues no reads
    for (int i = 0; i < 5; i++) begin
      mem_rdata = 16'h0F0F + 16'(i);
      cyc();
      chk("hold_ir", ir, 16'h5555);
      chk("hold_mem_rd", {15'd0, mem_rd}, 16'd0);
      chk("hold_ir_valid", {15'd0, ir_valid}, 16'd1);
    end
    ir_ack = 1'b1;
    cyc();
    chk("hold_idle_rd", {15'd0, mem_rd}, 16'd0);
    chk("hold_idle_valid", {15'd0, ir_valid}, 16'd0);
    ir_ack = 1'b0;
    cyc();
    chk("hold_idle_rd2", {15'd0, mem_rd}, 16'd0);

    // Redirect in IDLE, then PC wrap
    pc_ld = 1'b1; pc_in = 16'hFFFF;
    cyc();
    chk("idle_ld_pc", pc_out, 16'hFFFF);
    chk("idle_ld_rd", {15'd0, mem_rd}, 16'd0);
    chk("idle_ld_ir", ir, 16'h5555);
    pc_ld = 1'b0; run = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h7777;
    expq.push_back({16'h7777, 16'h0000});
    cyc();
    chk("wrap_mem_addr", mem_addr, 16'hFFFF);
    cyc();
    chk("wrap_pc_out", pc_out, 16'h0000);
    ir_ack = 1'b1;

    // Back-to-back: one instruction every two cycles
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("b2b_mem_rd", {15'd0, mem_rd}, 16'd1);
      chk("b2b_mem_addr", mem_addr, 16'(i - 1));
      mem_rdata = 16'h1000 + 16'(i);
      expq.push_back({16'h1000 + 16'(i), 16'(i)});
      cyc();
      chk("b2b_ir_valid", {15'd0, ir_valid}, 16'd1);
    end

    // Reset during FETCH with a response pending
    cyc();
    chk("rf_mem_rd", {15'd0, mem_rd}, 16'd1);
    rst = 1'b1; mem_rdata = 16'h9999;
    cyc();
    chk("rf_ir", ir, 16'h0000);
    chk("rf_pc_out", pc_out, 16'h3000);
    chk("rf_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("rf_mem_rd0", {15'd0, mem_rd}, 16'd0);
    rst = 1'b0; run = 1'b0; ir_ack = 1'b0;
    cyc();
    chk("rf_after_ir", ir, 16'h0000);
    chk("rf_after_valid", {15'd0, ir_valid}, 16'd0);

    cyc();
    chk("queue_drained", 16'(expq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
